// File: rtl/vm_pkg.sv
// Shared constants and FSM state encoding for the change dispenser.
package vm_pkg;

  localparam int unsigned COIN_1  = 1;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;

  localparam int unsigned HOP_1  = 0;
  localparam int unsigned HOP_5  = 1;
  localparam int unsigned HOP_10 = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSelect  = 3'd1,
    StPulse   = 3'd2,
    StWaitAck = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/coin_inventory.sv
// Per-hopper coin counters with load, decrement and jam-clear; load has priority.
module coin_inventory
  import vm_pkg::*;
#(
  parameter int unsigned INV_W     = 6,
  parameter int unsigned INV_RESET = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [1:0]       sel_i,
  input  logic [INV_W-1:0] val_i,
  input  logic [2:0]       dec_i,
  input  logic [2:0]       clr_i,
  output logic [2:0]       empty_o
);

  logic [INV_W-1:0] cnt_q [3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= INV_W'(INV_RESET);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load_i && (sel_i == 2'(i))) begin
          cnt_q[i] <= val_i;
        end else if (clr_i[i]) begin
          cnt_q[i] <= '0;
        end else if (dec_i[i] && (cnt_q[i] != '0)) begin
          // Saturate at zero rather than wrap
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    empty_o = '0;
    for (int i = 0; i < 3; i++) empty_o[i] = (cnt_q[i] == '0);
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Greedy coin payout sequencer: pulses one hopper at a time, waits for the drop
// sensor, and falls back to smaller coins when a hopper runs dry or jams.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W          = 4,
  parameter int unsigned INV_W          = 6,
  parameter int unsigned INV_RESET      = 8,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  input  logic [AMT_W-1:0] req_amount_i,
  output logic             req_ready_o,
  output logic [2:0]       eject_o,
  input  logic [2:0]       coin_seen_i,
  input  logic             inv_load_i,
  input  logic [1:0]       inv_sel_i,
  input  logic [INV_W-1:0] inv_val_i,
  output logic [2:0]       inv_empty_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AMT_W-1:0] shortfall_o,
  output logic             error_o
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);
  localparam logic [AMT_W-1:0] Coin1  = AMT_W'(COIN_1);
  localparam logic [AMT_W-1:0] Coin5  = AMT_W'(COIN_5);
  localparam logic [AMT_W-1:0] Coin10 = AMT_W'(COIN_10);

  state_e           state_q;
  logic [AMT_W-1:0] remaining_q;
  logic [TmrW-1:0]  timer_q;
  logic [1:0]       sel_hop_q;
  logic [AMT_W-1:0] sel_val_q;
  logic [2:0]       eject_q;
  logic             done_q;
  logic [AMT_W-1:0] shortfall_q;
  logic             error_q;

  logic [2:0]       inv_empty;
  logic [2:0]       inv_dec;
  logic [2:0]       inv_clr;
  logic [2:0]       sel_oh;
  logic             active;
  logic             ack;
  logic             tmo;
  logic             pick_found;
  logic [1:0]       pick_hop;
  logic [AMT_W-1:0] pick_val;

  // Largest coin that fits the remainder and still has stock
  always_comb begin
    pick_found = 1'b1;
    pick_hop   = 2'(HOP_10);
    pick_val   = Coin10;
    if ((remaining_q >= Coin10) && !inv_empty[HOP_10]) begin
      pick_hop = 2'(HOP_10);
      pick_val = Coin10;
    end else if ((remaining_q >= Coin5) && !inv_empty[HOP_5]) begin
      pick_hop = 2'(HOP_5);
      pick_val = Coin5;
    end else if ((remaining_q >= Coin1) && !inv_empty[HOP_1]) begin
      pick_hop = 2'(HOP_1);
      pick_val = Coin1;
    end else begin
      pick_found = 1'b0;
    end
  end

  always_comb begin
    sel_oh  = 3'b001 << sel_hop_q;
    active  = (state_q == StPulse) || (state_q == StWaitAck);
    ack     = active && ((coin_seen_i & sel_oh) != 3'b000);
    tmo     = active && !ack && (timer_q == TmrW'(TIMEOUT_CYCLES - 1));
    inv_dec = ack ? sel_oh : 3'b000;
    inv_clr = tmo ? sel_oh : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      timer_q     <= '0;
      sel_hop_q   <= '0;
      sel_val_q   <= '0;
      eject_q     <= '0;
      done_q      <= 1'b0;
      shortfall_q <= '0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            remaining_q <= req_amount_i;
            error_q     <= 1'b0;
            state_q     <= StSelect;
          end
        end
        StSelect: begin
          if (pick_found) begin
            sel_hop_q <= pick_hop;
            sel_val_q <= pick_val;
            timer_q   <= '0;
            eject_q   <= 3'b001 << pick_hop;
            state_q   <= StPulse;
          end else begin
            shortfall_q <= remaining_q;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StPulse, StWaitAck: begin
          timer_q <= timer_q + 1'b1;
          if (ack) begin
            remaining_q <= remaining_q - sel_val_q;
            eject_q     <= '0;
            state_q     <= StSelect;
          end else if (tmo) begin
            error_q <= 1'b1;
            eject_q <= '0;
            state_q <= StSelect;
          end else if ((state_q == StPulse) && (timer_q == TmrW'(PULSE_CYCLES - 1))) begin
            eject_q <= '0;
            state_q <= StWaitAck;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  coin_inventory #(
    .INV_W    (INV_W),
    .INV_RESET(INV_RESET)
  ) u_inv (
    .clk    (clk),
    .reset  (reset),
    .load_i (inv_load_i),
    .sel_i  (inv_sel_i),
    .val_i  (inv_val_i),
    .dec_i  (inv_dec),
    .clr_i  (inv_clr),
    .empty_o(inv_empty)
  );

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign eject_o     = eject_q;
  assign done_o      = done_q;
  assign shortfall_o = shortfall_q;
  assign error_o     = error_q;
  assign inv_empty_o = inv_empty;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomised bench for change_dispense_ctrl against a greedy-payout reference model.
module tb_change_dispense_ctrl;

  localparam int AMT_W          = 4;
  localparam int INV_W          = 6;
  localparam int INV_RESET      = 8;
  localparam int PULSE_CYCLES   = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic [2:0]       eject;
  logic [2:0]       coin_seen;
  logic             inv_load;
  logic [1:0]       inv_sel;
  logic [INV_W-1:0] inv_val;
  logic [2:0]       inv_empty;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             error;

  always #5 clk = ~clk;

  change_dispense_ctrl #(
    .AMT_W(AMT_W), .INV_W(INV_W), .INV_RESET(INV_RESET),
    .PULSE_CYCLES(PULSE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_amount_i(req_amount),
    .req_ready_o(req_ready), .eject_o(eject), .coin_seen_i(coin_seen),
    .inv_load_i(inv_load), .inv_sel_i(inv_sel), .inv_val_i(inv_val),
    .inv_empty_o(inv_empty), .busy_o(busy), .done_o(done), .shortfall_o(shortfall),
    .error_o(error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int    m_inv [3];
  string exp_str;
  int    exp_short;
  bit    exp_err;

  // Observations from the driver
  string obs_str;
  int    obs_short, obs_done_cyc, obs_first, obs_err_k, obs_badw, obs_busy_bad;
  bit    obs_done, obs_err;
  logic  obs_ready_after, obs_done_after;

  function automatic int denom(input int h);
    return (h == 2) ? 10 : (h == 1) ? 5 : 1;
  endfunction

  // Greedy payout: a jammed hopper drops no coin, is zeroed, and raises the error
  task automatic model(input int amt, input bit [2:0] jam, input int load_hop, input int load_val);
    int rem, h;
    bit loaded;
    rem = amt; loaded = 0; exp_str = ""; exp_err = 0;
    while (1) begin
      h = -1;
      for (int c = 2; c >= 0; c--) if (h < 0 && denom(c) <= rem && m_inv[c] > 0) h = c;
      if (h < 0) break;
      exp_str = {exp_str, $sformatf("%0d ", denom(h))};
      if (jam[h]) begin
        m_inv[h] = 0; exp_err = 1;
      end else begin
        rem -= denom(h);
        if (h == load_hop && !loaded) begin m_inv[h] = load_val; loaded = 1; end
        else m_inv[h]--;
      end
    end
    exp_short = rem;
  endtask

  task automatic load_inv(input int sel, input int val);
    inv_load = 1'b1; inv_sel = 2'(sel); inv_val = val[INV_W-1:0];
    @(posedge clk); #1;
    inv_load = 1'b0;
    if (sel < 3) m_inv[sel] = val;
  endtask

  // Issues one request and plays the hoppers until done (bounded)
  task automatic run_req(input int amt, input bit [2:0] jam, input int dmin, input int dmax,
                         input int load_hop, input int load_val, input bit poke);
    int k, delay, hop, width, exp_w;
    bit pending, loaded;
    logic [2:0] prev_ej;
    obs_str = ""; obs_short = -1; obs_done_cyc = -1; obs_first = -1; obs_err_k = -1;
    obs_badw = 0; obs_busy_bad = 0; obs_done = 0; obs_err = 0;
    pending = 0; loaded = 0; hop = 0; k = 0; delay = -1; width = 0; prev_ej = '0;
    req_valid = 1'b1; req_amount = amt[AMT_W-1:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc < 1000; cyc++) begin
      coin_seen = '0; inv_load = 1'b0;
      if (poke) begin
        req_valid = 1'($urandom_range(0, 1)); req_amount = AMT_W'($urandom);
      end
      if (req_ready !== 1'b0 || busy !== 1'b1) obs_busy_bad++;
      if (done === 1'b1) begin
        obs_done = 1; obs_short = int'(shortfall); obs_err = error; obs_done_cyc = cyc;
        break;
      end
      if (eject !== 3'b000 && prev_ej === 3'b000) begin
        if (pending) obs_badw++;
        hop = (eject === 3'b100) ? 2 : (eject === 3'b010) ? 1 : 0;
        obs_str = {obs_str, $sformatf("%0d ", denom(hop))};
        if (obs_first < 0) obs_first = cyc;
        k = 0; width = 0; pending = !jam[hop];
        delay = pending ? int'($urandom_range(dmin, dmax)) : -1;
      end
      if (eject !== 3'b000) begin
        width++;
        if (eject !== (3'b001 << hop)) obs_badw++;
        coin_seen = 3'($urandom) & ~(3'b001 << hop);
      end else if (prev_ej !== 3'b000) begin
        exp_w = (delay >= 0 && delay < PULSE_CYCLES) ? delay + 1 : PULSE_CYCLES;
        if (width != exp_w) obs_badw++;
      end
      if (error === 1'b1 && obs_err_k < 0) obs_err_k = k;
      if (pending && k == delay) begin
        coin_seen[hop] = 1'b1; pending = 0;
        if (hop == load_hop && !loaded) begin
          inv_load = 1'b1; inv_sel = 2'(hop); inv_val = load_val[INV_W-1:0]; loaded = 1;
        end
      end
      k++; prev_ej = eject;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; coin_seen = '0; inv_load = 1'b0;
    @(posedge clk); #1;
    obs_ready_after = req_ready; obs_done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    n_checks++; if ({busy, done, error, eject} !== 6'b0) begin n_fail++; $display("FAIL rst_ctl: got busy/done/err/eject=%b expected 0", {busy, done, error, eject}); end
    n_checks++; if (shortfall !== '0) begin n_fail++; $display("FAIL rst_short: got %0d expected 0", shortfall); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      m_inv[i] = INV_RESET;
      n_checks++; if (int'(dut.u_inv.cnt_q[i]) !== m_inv[i]) begin n_fail++; $display("FAIL rst_inv%0d: got %0d expected %0d", i, dut.u_inv.cnt_q[i], m_inv[i]); end
    end
    n_checks++; if (inv_empty !== 3'b000) begin n_fail++; $display("FAIL rst_empty: got %b expected 000", inv_empty); end
  endtask

  task automatic test_greedy();
    load_inv(2, 3); load_inv(1, 3); load_inv(0, 3);
    model(15, 3'b000, -1, 0);
    run_req(15, 3'b000, 2, 2, -1, 0, 0);
    n_checks++; if (obs_str != exp_str) begin n_fail++; $display("FAIL greedy_seq: got '%s' expected '%s'", obs_str, exp_str); end
    n_checks++; if (obs_done !== 1'b1 || obs_short !== exp_short) begin n_fail++; $display("FAIL greedy_short: got done=%0d short=%0d expected done=1 short=%0d", obs_done, obs_short, exp_short); end
    n_checks++; if (obs_first !== 2) begin n_fail++; $display("FAIL greedy_latency: got first eject at %0d expected 2", obs_first); end
    n_checks++; if (obs_badw !== 0 || obs_busy_bad !== 0) begin n_fail++; $display("FAIL greedy_pulse: got %0d bad pulses, %0d busy errors expected 0", obs_badw, obs_busy_bad); end
    n_checks++; if (obs_ready_after !== 1'b1 || obs_done_after !== 1'b0) begin n_fail++; $display("FAIL greedy_after: got ready=%b done=%b expected 1/0", obs_ready_after, obs_done_after); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (int'(dut.u_inv.cnt_q[i]) !== m_inv[i]) begin n_fail++; $display("FAIL greedy_inv%0d: got %0d expected %0d", i, dut.u_inv.cnt_q[i], m_inv[i]); end
    end
  endtask

  task automatic test_shortfall();
    load_inv(1, 0); load_inv(0, 2);
    model(7, 3'b000, -1, 0);
    run_req(7, 3'b000, 0, 6, -1, 0, 0);
    n_checks++; if (obs_str != exp_str) begin n_fail++; $display("FAIL short_seq: got '%s' expected '%s'", obs_str, exp_str); end
    n_checks++; if (obs_done !== 1'b1 || obs_short !== exp_short) begin n_fail++; $display("FAIL short_val: got done=%0d short=%0d expected done=1 short=%0d", obs_done, obs_short, exp_short); end
    n_checks++; if (inv_empty[0] !== (m_inv[0] == 0)) begin n_fail++; $display("FAIL short_empty0: got %b expected %b", inv_empty[0], m_inv[0] == 0); end
    n_checks++; if (obs_badw !== 0) begin n_fail++; $display("FAIL short_pulse: got %0d bad pulses expected 0", obs_badw); end
  endtask

  task automatic test_timeout();
    load_inv(2, 3); load_inv(1, 2);
    model(10, 3'b100, -1, 0);
    run_req(10, 3'b100, 0, 8, -1, 0, 0);
    n_checks++; if (obs_str != exp_str) begin n_fail++; $display("FAIL tmo_seq: got '%s' expected '%s'", obs_str, exp_str); end
    n_checks++; if (obs_done !== 1'b1 || obs_short !== exp_short || obs_err !== exp_err) begin n_fail++; $display("FAIL tmo_done: got done=%0d short=%0d err=%0d expected 1/%0d/%0d", obs_done, obs_short, obs_err, exp_short, exp_err); end
    n_checks++; if (obs_err_k !== TIMEOUT_CYCLES) begin n_fail++; $display("FAIL tmo_when: got error at %0d cycles expected %0d", obs_err_k, TIMEOUT_CYCLES); end
    n_checks++; if (inv_empty[2] !== (m_inv[2] == 0)) begin n_fail++; $display("FAIL tmo_empty2: got %b expected %b", inv_empty[2], m_inv[2] == 0); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", error); end
    n_checks++; if (obs_badw !== 0) begin n_fail++; $display("FAIL tmo_pulse: got %0d bad pulses expected 0", obs_badw); end
    load_inv(0, 4);
    model(1, 3'b000, -1, 0);
    run_req(1, 3'b000, 0, 5, -1, 0, 0);
    n_checks++; if (obs_done !== 1'b1 || obs_err !== exp_err || error !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got done=%0d err=%0d/%b expected 1/%0d/0", obs_done, obs_err, error, exp_err); end
  endtask

  task automatic test_back_to_back();
    model(0, 3'b000, -1, 0);
    run_req(0, 3'b000, 0, 0, -1, 0, 1);
    n_checks++; if (obs_done_cyc !== 2 || obs_str != exp_str) begin n_fail++; $display("FAIL zero_done: got done at %0d ejects '%s' expected 2 ''", obs_done_cyc, obs_str); end
    n_checks++; if (obs_busy_bad !== 0 || obs_short !== exp_short) begin n_fail++; $display("FAIL zero_busy: got %0d busy errors short=%0d expected 0/%0d", obs_busy_bad, obs_short, exp_short); end
    model(6, 3'b000, -1, 0);
    run_req(6, 3'b000, 0, 6, -1, 0, 1);
    n_checks++; if (obs_str != exp_str || obs_short !== exp_short) begin n_fail++; $display("FAIL poke_seq: got '%s' short=%0d expected '%s' short=%0d", obs_str, obs_short, exp_str, exp_short); end
    n_checks++; if (obs_busy_bad !== 0 || obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL poke_ready: got %0d busy errors ready_after=%b expected 0/1", obs_busy_bad, obs_ready_after); end
  endtask

  task automatic test_load_on_ack();
    load_inv(1, 2);
    model(5, 3'b000, 1, 9);
    run_req(5, 3'b000, 0, 6, 1, 9, 0);
    n_checks++; if (obs_str != exp_str || obs_short !== exp_short) begin n_fail++; $display("FAIL ldack_seq: got '%s' short=%0d expected '%s' short=%0d", obs_str, obs_short, exp_str, exp_short); end
    n_checks++; if (int'(dut.u_inv.cnt_q[1]) !== m_inv[1]) begin n_fail++; $display("FAIL ldack_inv5: got %0d expected %0d", dut.u_inv.cnt_q[1], m_inv[1]); end
  endtask

  task automatic test_reset_mid();
    load_inv(2, 3);
    req_valid = 1'b1; req_amount = 4'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && eject === 3'b000; i++) begin @(posedge clk); #1; end
    n_checks++; if (eject !== 3'b100) begin n_fail++; $display("FAIL rmid_start: got eject %b expected 100", eject); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (eject !== 3'b000 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got eject=%b done=%b expected 000/0", eject, done); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got ready=%b done=%b expected 1/0", req_ready, done); end
    for (int i = 0; i < 3; i++) begin
      m_inv[i] = INV_RESET;
      n_checks++; if (int'(dut.u_inv.cnt_q[i]) !== m_inv[i]) begin n_fail++; $display("FAIL rmid_inv%0d: got %0d expected %0d", i, dut.u_inv.cnt_q[i], m_inv[i]); end
    end
  endtask

  task automatic test_random();
    int amt;
    bit [2:0] jam;
    bit poke;
    logic [2:0] exp_empty;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) != 0) load_inv(i, int'($urandom_range(0, 3)));
      amt = int'($urandom_range(0, 15));
      jam = '0;
      if ($urandom_range(0, 3) == 0) jam[$urandom_range(0, 2)] = 1'b1;
      poke = 1'($urandom_range(0, 1));
      model(amt, jam, -1, 0);
      run_req(amt, jam, 0, 7, -1, 0, poke);
      for (int i = 0; i < 3; i++) exp_empty[i] = (m_inv[i] == 0);
      n_checks++; if (obs_str != exp_str) begin n_fail++; $display("FAIL rand%0d_seq: amt=%0d got '%s' expected '%s'", it, amt, obs_str, exp_str); end
      n_checks++; if (obs_done !== 1'b1 || obs_short !== exp_short || obs_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_done: got done=%0d short=%0d err=%0d expected 1/%0d/%0d", it, obs_done, obs_short, obs_err, exp_short, exp_err); end
      n_checks++; if (obs_err_k !== (exp_err ? TIMEOUT_CYCLES : -1)) begin n_fail++; $display("FAIL rand%0d_tmo: got error at %0d expected %0d", it, obs_err_k, exp_err ? TIMEOUT_CYCLES : -1); end
      n_checks++; if (obs_badw !== 0 || obs_busy_bad !== 0) begin n_fail++; $display("FAIL rand%0d_pulse: got %0d bad pulses %0d busy errors expected 0", it, obs_badw, obs_busy_bad); end
      n_checks++; if (obs_first !== ((exp_str == "") ? -1 : 2)) begin n_fail++; $display("FAIL rand%0d_lat: got first eject %0d expected %0d", it, obs_first, (exp_str == "") ? -1 : 2); end
      n_checks++; if (inv_empty !== exp_empty) begin n_fail++; $display("FAIL rand%0d_empty: got %b expected %b", it, inv_empty, exp_empty); end
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (int'(dut.u_inv.cnt_q[i]) !== m_inv[i]) begin n_fail++; $display("FAIL rand%0d_inv%0d: got %0d expected %0d", it, i, dut.u_inv.cnt_q[i], m_inv[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_amount = '0; coin_seen = '0;
    inv_load = 1'b0; inv_sel = '0; inv_val = '0;
    test_reset();
    test_greedy();
    test_shortfall();
    test_timeout();
    test_back_to_back();
    test_load_on_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
